cpu_mem_responder: RTL and testbench

- Memory-side responder for the multicycle core's memory port. The core's control FSM initiates fetch, load and store accesses; this block is the far end that answers them.
- Accepts one word request at a time through a valid/ready handshake and holds it for a programmable number of wait states.
- Performs the read or write on an internal word array, then returns a single-cycle response carrying read data and an error flag.
- Keeps a saturating count of faulted accesses for debug.

---
 rtl/cpu_mem_responder.sv | 123 ++++++++++++
 tb/tb_cpu_mem_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the multicycle core: one word request at a time, a fixed
// number of wait states, then a single-cycle response with read data and an error flag.
module cpu_mem_responder #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [7:0]        err_count
);

  localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q;
  logic [3:0]          wait_cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   mem [DEPTH_WORDS];

  logic                cmt_en;
  logic                cmt_we;
  logic                cmt_fault;
  logic [ADDR_W-1:0]   cmt_addr;
  logic [DATA_W-1:0]   cmt_wdata;
  logic [IdxW-1:0]     cmt_idx;

  // With no wait states the commit edge is the accept edge, so the request comes straight
  // from the inputs; otherwise it comes from the values latched at accept.
  always_comb begin
    cmt_en    = 1'b0;
    cmt_we    = we_q;
    cmt_addr  = addr_q;
    cmt_wdata = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (WAIT_CYCLES == 0) begin
          cmt_en    = req_valid;
          cmt_we    = req_we;
          cmt_addr  = req_addr;
          cmt_wdata = req_wdata;
        end
      end
      StWait:  cmt_en = (wait_cnt_q == 4'd1);
      default: cmt_en = 1'b0;
    endcase
    cmt_idx   = cmt_addr[IdxW+1:2];
    // DEPTH_WORDS is a power of two, so "word index >= depth" is any set bit above the index.
    cmt_fault = (cmt_addr[1:0] != 2'b00) || (|cmt_addr[ADDR_W-1:IdxW+2]);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q      <= req_we;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state_q <= StResp;
            end else begin
              state_q    <= StWait;
              wait_cnt_q <= WaitInit;
            end
          end
        end
        StWait: begin
          wait_cnt_q <= wait_cnt_q - 4'd1;
          if (wait_cnt_q == 4'd1) state_q <= StResp;
        end
        StResp: begin
          state_q    <= StIdle;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: state_q <= StIdle;
      endcase

      if (cmt_en) begin
        resp_valid <= 1'b1;
        if (cmt_fault) begin
          resp_err   <= 1'b1;
          resp_rdata <= '0;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end else begin
          resp_err   <= 1'b0;
          resp_rdata <= cmt_we ? '0 : mem[cmt_idx];
        end
      end
    end
  end

  // Array is never cleared; a reset on the commit edge discards the store.
  always_ff @(posedge clk) begin
    if (reset && cmt_en && cmt_we && !cmt_fault) mem[cmt_idx] <= cmt_wdata;
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Randomised bench: three responders (0, 1 and 3 wait states) checked against a
// word-array model with a saturating error counter.
module tb_cpu_mem_responder;

  localparam int NI    = 3;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset [NI];
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_we [NI];
  logic [31:0] req_addr [NI];
  logic [31:0] req_wdata [NI];
  logic        resp_valid [NI];
  logic [31:0] resp_rdata [NI];
  logic        resp_err [NI];
  logic [7:0]  err_count [NI];

  logic [31:0] mdl_mem [NI][DEPTH];
  int          mdl_err [NI];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    cpu_mem_responder #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .DEPTH_WORDS(DEPTH),
      .WAIT_CYCLES((g == 0) ? 1 : (g == 1) ? 0 : 3)
    ) u_dut (
      .clk       (clk),
      .reset     (reset[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .resp_valid(resp_valid[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g]),
      .err_count (err_count[g])
    );
  end

  function automatic int wc(input int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 3;
  endfunction

  function automatic bit is_fault(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= DEPTH);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One full transaction on instance k; optionally scrambles the inputs after accept.
  task automatic txn(input int k, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input bit scramble);
    int n;
    int lat;
    logic [31:0] exp_rdata;
    bit f;
    n = 0;
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_before_req", 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    @(negedge clk);
    req_valid[k] = 1'b0;
    if (scramble) begin
      req_we[k]    = ~we;
      req_addr[k]  = $urandom();
      req_wdata[k] = $urandom();
    end
    f = is_fault(addr);
    exp_rdata = 32'd0;
    if (f) begin
      if (mdl_err[k] < 255) mdl_err[k]++;
    end else if (we) begin
      mdl_mem[k][addr/4] = wdata;
    end else begin
      exp_rdata = mdl_mem[k][addr/4];
    end
    lat = 1;
    while (!resp_valid[k] && lat < 40) begin
      check_eq("ready_busy", 32'(req_ready[k]), 32'd0);
      @(negedge clk);
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(wc(k) + 1));
    check_eq("resp_err", 32'(resp_err[k]), 32'(f));
    check_eq("resp_rdata", resp_rdata[k], exp_rdata);
    check_eq("err_count", 32'(err_count[k]), 32'(mdl_err[k]));
    check_eq("ready_in_resp", 32'(req_ready[k]), 32'd0);
    @(negedge clk);
    check_eq("resp_valid_drop", 32'(resp_valid[k]), 32'd0);
    check_eq("resp_err_drop", 32'(resp_err[k]), 32'd0);
    check_eq("rdata_drop", resp_rdata[k], 32'd0);
    check_eq("ready_back", 32'(req_ready[k]), 32'd1);
  endtask

  task automatic check_idle(input int k);
    check_eq("idle_ready", 32'(req_ready[k]), 32'd1);
    check_eq("idle_resp_valid", 32'(resp_valid[k]), 32'd0);
    check_eq("idle_err_count", 32'(err_count[k]), 32'(mdl_err[k]));
  endtask

  initial begin
    int acc;
    bit prev_acc;
    bit cur;
    logic [31:0] a;

    for (int k = 0; k < NI; k++) begin
      reset[k]     = 1'b0;
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = '0;
      req_wdata[k] = '0;
      mdl_err[k]   = 0;
    end

    // 1. reset then idle
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) reset[k] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) check_idle(k);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++)
        check_eq("no_resp_idle", 32'(resp_valid[k]), 32'd0);
    end

    // preload a working set so every later load has defined contents
    for (int k = 0; k < NI; k++)
      for (int w = 0; w < 16; w++) txn(k, 1'b1, 32'(w * 4), $urandom(), 1'b0);

    // 2. store then load, one wait state
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0, 1'b0);
    check_eq("model_deadbeef", mdl_mem[0][4], 32'hDEADBEEF);

    // 3. zero wait states, req_valid held high: one accept every two cycles
    req_we[1]    = 1'b0;
    req_addr[1]  = 32'h10;
    req_valid[1] = 1'b1;
    acc = 0;
    prev_acc = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check_eq("b2b_resp", 32'(resp_valid[1]), 32'(prev_acc));
      if (prev_acc) check_eq("b2b_rdata", resp_rdata[1], mdl_mem[1][4]);
      cur = req_ready[1] && req_valid[1];
      if (cur) acc++;
      req_valid[1] = cur || (acc < 4);
      prev_acc = cur;
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    check_eq("b2b_accepts", 32'(acc), 32'd4);

    // 4. faults
    txn(0, 1'b0, 32'h13, 32'h0, 1'b0);
    txn(0, 1'b1, 32'(4 * DEPTH), 32'hCAFEF00D, 1'b0);
    txn(0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_eq("err_count_two", 32'(err_count[0]), 32'd2);
    for (int i = 0; i < 300; i++) begin
      a = $urandom();
      if (!is_fault(a)) a = a | 32'h1;
      txn(0, i[0], a, $urandom(), 1'b0);
    end
    check_eq("err_count_sat", 32'(err_count[0]), 32'd255);

    // 5. reset during WAIT aborts the store
    txn(2, 1'b1, 32'h20, 32'h11111111, 1'b0);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_addr[2]  = 32'h20;
    req_wdata[2] = 32'h12345678;
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    reset[2] = 1'b0;
    mdl_err[2] = 0;
    for (int c = 0; c < 2; c++) begin
      check_eq("abort_no_resp", 32'(resp_valid[2]), 32'd0);
      @(negedge clk);
    end
    reset[2] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      check_eq("abort_no_resp", 32'(resp_valid[2]), 32'd0);
      @(negedge clk);
    end
    check_idle(2);
    txn(2, 1'b0, 32'h20, 32'h0, 1'b0);

    // 6. inputs changed while busy are ignored
    txn(2, 1'b1, 32'h24, 32'hA5A55A5A, 1'b1);
    txn(2, 1'b0, 32'h24, 32'h0, 1'b1);
    txn(0, 1'b1, 32'h28, 32'h0F0F0F0F, 1'b1);
    txn(0, 1'b0, 32'h28, 32'h0, 1'b1);

    // random mix on every instance
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 40; i++) begin
        case ($urandom_range(0, 9))
          0:       a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
          1:       a = 32'(4 * DEPTH) + 32'($urandom_range(0, 4095)) * 4;
          default: a = 32'($urandom_range(0, 15)) * 4;
        endcase
        txn(k, 1'($urandom_range(0, 1)), a, $urandom(), 1'($urandom_range(0, 1)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
